// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the AXI4 stream write master.
package axi_wr_pkg;

  typedef enum logic [2:0] {IDLE, CALC, AW, W, B, DONE} wr_state_t;

  localparam int BOUNDARY_4K = 4096;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/stream_fifo.sv
// Show-ahead synchronous FIFO with level output and a synchronous flush.
module stream_fifo #(
  parameter int DSIZE = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DSIZE-1:0]         din,
  output logic [DSIZE-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/axi4_stream_wr_master.sv
// Stream-to-AXI4 write DMA: buffers beats and issues one 4KB-safe INCR burst at a time.
// Optional B-response watchdog enabled by defining AXI4_WR_BTIMEOUT_EN.
module axi4_stream_wr_master
  import axi_wr_pkg::*;
#(
  parameter int ASIZE          = 32,
  parameter int LSIZE          = 8,
  parameter int DSIZE          = 32,
  parameter int MAX_BURST      = 16,
  parameter int FIFO_DEPTH     = 32,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic [ASIZE-1:0] base_addr,
  input  logic [LEN_W-1:0] total_beats,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] in_data,
  output logic             in_ready,
  output logic [ASIZE-1:0] axi_awaddr,
  output logic [LSIZE-1:0] axi_awlen,
  output logic             axi_awvalid,
  input  logic             axi_awready,
  output logic [DSIZE-1:0] axi_wdata,
  output logic             axi_wlast,
  output logic             axi_wvalid,
  input  logic             axi_wready,
  input  logic [1:0]       axi_bresp,
  input  logic             axi_bvalid,
  output logic             axi_bready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output wr_state_t        dbg_state
);

  // Handshakes: a transfer occurs on a cycle where valid && ready are both high
  // at the rising clock edge; a raised valid and its payload hold until then.

  localparam int BPB       = DSIZE / 8;
  localparam int BPB_SHIFT = $clog2(BPB);
  localparam int BW        = $clog2(MAX_BURST) + 1;
  localparam int LW        = $clog2(FIFO_DEPTH) + 1;

  wr_state_t        state_q, state_d;
  logic [ASIZE-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0] total_q, total_d;
  logic [LEN_W-1:0] accepted_q, accepted_d;
  logic [BW-1:0]    blen_q, blen_d;
  logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
  logic             err_q, err_d;

`ifdef AXI4_WR_BTIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
`endif

  logic             fifo_push, fifo_pop, fifo_flush;
  logic             fifo_full, fifo_empty;
  logic [DSIZE-1:0] fifo_dout;
  logic [LW-1:0]    fifo_level;

  logic [12:0]      bytes_to_4k, beats_to_4k;
  logic [BW-1:0]    blen_calc;

  stream_fifo #(
    .DSIZE (DSIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Burst length is the tightest of: beats left, burst cap, beats to the 4KB page end.
  always_comb begin
    bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, cur_addr_q[11:0]};
    beats_to_4k = bytes_to_4k >> BPB_SHIFT;
    blen_calc   = BW'(MAX_BURST);
    if (remaining_q < LEN_W'(MAX_BURST)) blen_calc = remaining_q[BW-1:0];
    if (beats_to_4k < 13'(blen_calc))    blen_calc = beats_to_4k[BW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    total_d     = total_q;
    blen_d      = blen_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
`ifdef AXI4_WR_BTIMEOUT_EN
    to_cnt_d    = '0;
`endif
    axi_awaddr  = '0;
    axi_awlen   = '0;
    axi_awvalid = 1'b0;
    axi_wdata   = '0;
    axi_wlast   = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    done        = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;

    busy       = (state_q != IDLE);
    in_ready   = busy && !fifo_full && (accepted_q < total_q);
    fifo_push  = in_valid && in_ready;
    accepted_d = accepted_q + LEN_W'(fifo_push);

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_addr_d  = base_addr & ~ASIZE'(BPB - 1);
          remaining_d = total_beats;
          total_d     = total_beats;
          accepted_d  = '0;
          err_d       = 1'b0;
          state_d     = (total_beats == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        blen_d = blen_calc;
        // Waiting for the whole burst keeps W from stalling while the interconnect is locked.
        if (int'(fifo_level) >= int'(blen_calc)) state_d = AW;
      end
      AW: begin
        axi_awvalid = 1'b1;
        axi_awaddr  = cur_addr_q;
        axi_awlen   = LSIZE'(blen_q - BW'(1));
        if (axi_awready) begin
          beat_cnt_d = '0;
          state_d    = W;
        end
      end
      W: begin
        axi_wvalid = !fifo_empty;
        axi_wdata  = fifo_empty ? '0 : fifo_dout;
        axi_wlast  = axi_wvalid && (beat_cnt_q == blen_q - BW'(1));
        if (axi_wvalid && axi_wready) begin
          fifo_pop   = 1'b1;
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (axi_wlast) begin
            beat_cnt_d = '0;
            state_d    = B;
          end
        end
      end
      B: begin
        axi_bready = 1'b1;
        if (axi_bvalid) begin
          err_d       = err_q | (axi_bresp != RESP_OKAY);
          cur_addr_d  = cur_addr_q + (ASIZE'(blen_q) << BPB_SHIFT);
          remaining_d = remaining_q - LEN_W'(blen_q);
          state_d     = (remaining_d == '0) ? DONE : CALC;
        end
`ifdef AXI4_WR_BTIMEOUT_EN
        else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
`endif
      end
      DONE: begin
        done       = 1'b1;
        fifo_flush = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      total_q     <= '0;
      accepted_q  <= '0;
      blen_q      <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
`ifdef AXI4_WR_BTIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      total_q     <= total_d;
      accepted_q  <= accepted_d;
      blen_q      <= blen_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
`ifdef AXI4_WR_BTIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_axi4_stream_wr_master.sv
// Randomized bench for axi4_stream_wr_master with a burst-plan model and data scoreboard.
module tb_axi4_stream_wr_master;
  import axi_wr_pkg::*;

  localparam int ASIZE          = 32;
  localparam int LSIZE          = 8;
  localparam int DSIZE          = 32;
  localparam int MAX_BURST      = 16;
  localparam int FIFO_DEPTH     = 32;
  localparam int LEN_W          = 16;
  localparam int TIMEOUT_CYCLES = 1024;
  localparam int BUDGET         = 4000;

  logic             clock = 1'b0;
  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic [ASIZE-1:0] base_addr = '0;
  logic [LEN_W-1:0] total_beats = '0;
  logic             in_valid = 1'b0;
  logic [DSIZE-1:0] in_data = '0;
  logic             in_ready;
  logic [ASIZE-1:0] axi_awaddr;
  logic [LSIZE-1:0] axi_awlen;
  logic             axi_awvalid;
  logic             axi_awready = 1'b0;
  logic [DSIZE-1:0] axi_wdata;
  logic             axi_wlast;
  logic             axi_wvalid;
  logic             axi_wready = 1'b0;
  logic [1:0]       axi_bresp = 2'b00;
  logic             axi_bvalid = 1'b0;
  logic             axi_bready;
  logic             busy, done, err;
  wr_state_t        dbg_state;

  axi4_stream_wr_master #(
    .ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST),
    .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock), .rst(rst), .start(start), .base_addr(base_addr),
    .total_beats(total_beats), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_wdata(axi_wdata),
    .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus knobs ----------------
  int stream_pct    = 100;
  int stream_period = 0;
  int aw_pct        = 100;
  int w_pct         = 100;
  int b_delay_max   = 0;
  int err_burst     = -1;
  int b_idx         = 0;
  bit b_never       = 1'b0;
  bit beat_taken    = 1'b0;

  // ---------------- scoreboard state ----------------
  logic [DSIZE-1:0]       exp_q[$];
  logic [ASIZE+LSIZE-1:0] exp_aw_q[$];
  int  aw_cnt, w_cnt, in_cnt, done_cnt, gap_cnt, in_ready_cnt, bready_cyc;
  int  cur_len, wbeat, level_at_aw, last_lat;
  bit  aw_seen;

  // Reference plan: split the transfer at the burst cap and at every 4KB page end.
  function automatic int plan_bursts(input logic [ASIZE-1:0] base, input int total);
    logic [ASIZE-1:0] a;
    int rem, n, room, nb;
    a   = base & ~32'h3;
    rem = total;
    nb  = 0;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      n = rem;
      if (n > MAX_BURST) n = MAX_BURST;
      if (n > room) n = room;
      exp_aw_q.push_back({a, 8'(n - 1)});
      a   = a + 32'(n * 4);
      rem = rem - n;
      nb++;
    end
    return nb;
  endfunction

  task automatic clear_sb();
    exp_q.delete();
    exp_aw_q.delete();
    aw_cnt = 0; w_cnt = 0; in_cnt = 0; done_cnt = 0; gap_cnt = 0;
    in_ready_cnt = 0; bready_cyc = 0; cur_len = 0; wbeat = 0;
    level_at_aw = 0; aw_seen = 1'b0; b_idx = 0;
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (rst) begin
      beat_taken = 1'b0;
    end else begin
      if (axi_awvalid && !aw_seen) begin
        level_at_aw = in_cnt - w_cnt;
        aw_seen = 1'b1;
      end
      if (wbeat > 0 && wbeat < cur_len && !axi_wvalid) gap_cnt++;
      if (in_ready) in_ready_cnt++;
      beat_taken = in_valid && in_ready;
      if (beat_taken) begin
        exp_q.push_back(in_data);
        in_cnt++;
      end
      if (axi_awvalid && axi_awready) begin
        logic [ASIZE+LSIZE-1:0] e;
        aw_cnt++;
        if (exp_aw_q.size() == 0) begin
          check_eq("aw_extra", 1, 0);
        end else begin
          e = exp_aw_q.pop_front();
          check_eq("awaddr", axi_awaddr, e[ASIZE+LSIZE-1:LSIZE]);
          check_eq("awlen", axi_awlen, e[LSIZE-1:0]);
        end
        check_eq("aw_4k", (32'(axi_awaddr[11:0]) + (32'(axi_awlen) + 1) * 4) <= 4096, 1);
        cur_len = int'(axi_awlen) + 1;
        wbeat = 0;
      end
      if (axi_wvalid && axi_wready) begin
        w_cnt++;
        if (exp_q.size() == 0) check_eq("w_extra", 1, 0);
        else check_eq("wdata", axi_wdata, exp_q.pop_front());
        check_eq("wlast", axi_wlast, wbeat == cur_len - 1);
        wbeat++;
      end
      if (axi_bready) bready_cyc++;
      if (done) done_cnt++;
    end
  end

  // ---------------- driver processes ----------------
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clock); #1;
      cyc++;
      if (!in_valid || beat_taken) begin
        if (stream_period > 0) in_valid = (cyc % stream_period) == 0;
        else in_valid = $urandom_range(99) < stream_pct;
        in_data = $urandom;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock); #1;
      axi_awready = $urandom_range(99) < aw_pct;
      axi_wready  = $urandom_range(99) < w_pct;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (axi_bready && !b_never && !rst) begin
        repeat ($urandom_range(b_delay_max)) @(posedge clock);
        @(posedge clock); #1;
        axi_bvalid = 1'b1;
        axi_bresp  = (b_idx == err_burst) ? RESP_SLVERR : RESP_OKAY;
        @(posedge clock); #1;
        axi_bvalid = 1'b0;
        axi_bresp  = RESP_OKAY;
        b_idx++;
      end
    end
  end

  task automatic do_start(input logic [ASIZE-1:0] base, input int total);
    @(posedge clock); #1;
    start = 1'b1;
    base_addr = base;
    total_beats = LEN_W'(total);
    @(posedge clock); #1;
    start = 1'b0;
    base_addr = $urandom;
    total_beats = LEN_W'($urandom);
  endtask

  task automatic run_xfer(input string name, input logic [ASIZE-1:0] base, input int total,
                          input int err_idx);
    int nb, cyc, first_len;
    logic [ASIZE+LSIZE-1:0] e0;
    bit exp_err;
    clear_sb();
    nb = plan_bursts(base, total);
    first_len = 0;
    if (nb > 0) begin
      e0 = exp_aw_q[0];
      first_len = int'(e0[LSIZE-1:0]) + 1;
    end
    exp_err = (err_idx >= 0) && (err_idx < nb);
    err_burst = err_idx;
    do_start(base, total);
    cyc = 0;
    while (done_cnt == 0 && cyc < BUDGET) begin
      @(posedge clock);
      cyc++;
    end
    last_lat = cyc;
    check_eq({name, ":done_seen"}, done_cnt > 0, 1);
    repeat (3) @(posedge clock);
    #1;
    check_eq({name, ":done_once"}, done_cnt, 1);
    check_eq({name, ":err"}, err, exp_err);
    check_eq({name, ":busy_idle"}, busy, 0);
    check_eq({name, ":aw_count"}, aw_cnt, nb);
    check_eq({name, ":beats"}, w_cnt, total);
    check_eq({name, ":aw_left"}, exp_aw_q.size(), 0);
    check_eq({name, ":data_left"}, exp_q.size(), 0);
    check_eq({name, ":w_gaps"}, gap_cnt, 0);
    if (nb > 0) check_eq({name, ":aw_level"}, level_at_aw >= first_len, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [ASIZE-1:0] rb;
    logic [11:0] off;
    int rt;
    clear_sb();
    repeat (3) @(negedge clock);
    check_eq("rst_ctrl", {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, busy, done, err, in_ready}, 0);
    check_eq("rst_state", dbg_state, IDLE);
    #2 rst = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("idle_ctrl", {axi_awvalid, axi_wvalid, axi_bready, busy, done, err, in_ready}, 0);
    check_eq("idle_addr", axi_awaddr, 0);

    run_xfer("basic", 32'h0000_1000, 40, -1);
    run_xfer("cross4k", 32'h0000_0FF0, 8, -1);

    stream_period = 4;
    run_xfer("slow", 32'h0000_3000, 16, -1);
    check_eq("slow:level16", level_at_aw, 16);
    stream_period = 0;

    b_delay_max = 3;
    run_xfer("bresp_err", 32'h0000_2000, 40, 1);
    run_xfer("err_clear", 32'h0000_2400, 4, -1);
    b_delay_max = 0;

    run_xfer("zero", 32'h0000_5000, 0, -1);
    check_eq("zero:latency", last_lat <= 2, 1);
    check_eq("zero:in_ready", in_ready_cnt, 0);

    // Asynchronous reset in the middle of a W burst.
    clear_sb();
    void'(plan_bursts(32'h0000_6000, 40));
    do_start(32'h0000_6000, 40);
    rt = 0;
    while (w_cnt < 5 && rt < BUDGET) begin
      @(posedge clock);
      rt++;
    end
    check_eq("rst_mid:reached", w_cnt >= 5, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid:ctrl", {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, busy, done, err, in_ready}, 0);
    check_eq("rst_mid:awaddr", axi_awaddr, 0);
    check_eq("rst_mid:awlen", axi_awlen, 0);
    check_eq("rst_mid:wdata", axi_wdata, 0);
    check_eq("rst_mid:state", dbg_state, IDLE);
    repeat (2) @(negedge clock);
    #2 rst = 1'b0;
    run_xfer("after_rst", 32'h0000_7000, 24, -1);

    for (int i = 0; i < 12; i++) begin
      rb = $urandom;
      if ($urandom_range(1) == 1) begin
        off = 12'hF00 + 12'($urandom_range(255));
        rb[11:0] = off;
      end
      stream_pct  = $urandom_range(30, 100);
      aw_pct      = $urandom_range(30, 100);
      w_pct       = $urandom_range(30, 100);
      b_delay_max = $urandom_range(4);
      run_xfer("rand", rb, $urandom_range(1, 70),
               ($urandom_range(2) == 0) ? $urandom_range(0, 4) : -1);
    end

`ifdef AXI4_WR_BTIMEOUT_EN
    stream_pct = 100; aw_pct = 100; w_pct = 100;
    b_never = 1'b1;
    run_xfer("btimeout", 32'h0000_8000, 4, 0);
    check_eq("btimeout:bready_cycles", bready_cyc, TIMEOUT_CYCLES);
    b_never = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
